// File: rtl/rng_core_pkg.sv
// Shared defaults and types for the rng_core pseudo-random engine and its sample FIFO.
package rng_core_pkg;

    localparam int unsigned        RNG_DATA_WIDTH   = 32;
    localparam logic [31:0]        RNG_POLY         = 32'h8020_0003;
    localparam logic [31:0]        RNG_DEFAULT_SEED = 32'h0000_0001;
    localparam int unsigned        RNG_FIFO_DEPTH   = 4;
    localparam int unsigned        RNG_DIV_WIDTH    = 16;

    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_POP  = 2'b01,
        FIFO_OP_PUSH = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/rng_fifo.sv
// Synchronous sample FIFO with flush, occupancy and full flag; head reads as zero when empty.
module rng_fifo
    import rng_core_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o
);

    localparam int unsigned      PTR_W     = $clog2(DEPTH);
    localparam int unsigned      LVL_W     = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    fifo_op_e         w_op;

    assign w_empty   = (r_level == {LVL_W{1'b0}});
    assign w_full    = (r_level == DEPTH_LVL);
    assign w_do_pop  = pop_i && !w_empty;
    // A push into a full buffer only lands when a pop frees a slot on the same edge.
    assign w_do_push = push_i && (!w_full || w_do_pop);
    assign w_op      = fifo_op_e'({w_do_push, w_do_pop});

    assign dout_o  = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
    assign valid_o = !w_empty;
    assign level_o = r_level;
    assign full_o  = w_full;

    // Pointer and occupancy bookkeeping; flush wins over any push or pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else if (flush_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            case (w_op)
                FIFO_OP_PUSH: r_level <= r_level + LVL_W'(1'b1);
                FIFO_OP_POP:  r_level <= r_level - LVL_W'(1'b1);
                default:      r_level <= r_level;
            endcase
        end
    end

    // Sample storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= {WIDTH{1'b0}};
        end else if (!flush_i && w_do_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

endmodule

// File: rtl/rng_core.sv
// Galois-LFSR random source with step prescaler feeding a pop-able sample FIFO.
// Build option: define RNG_WHITEN_EN to half-swap-XOR each pushed sample (LFSR state untouched).
module rng_core
    import rng_core_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH   = RNG_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]  POLY         = RNG_POLY,
    parameter logic [DATA_WIDTH-1:0]  DEFAULT_SEED = RNG_DEFAULT_SEED,
    parameter int unsigned            FIFO_DEPTH   = RNG_FIFO_DEPTH,
    parameter int unsigned            DIV_WIDTH    = RNG_DIV_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          en_i,
    input  logic [DIV_WIDTH-1:0]          div_i,
    input  logic [DATA_WIDTH-1:0]         seed_i,
    input  logic                          seed_wr_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          full_o
);

    logic [DATA_WIDTH-1:0] r_lfsr;
    logic [DIV_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] w_next;
    logic [DATA_WIDTH-1:0] w_sample;
    logic                  w_step;
    logic                  w_push;
    logic                  w_pop;

    assign w_next = {1'b0, r_lfsr[DATA_WIDTH-1:1]} ^ (r_lfsr[0] ? POLY : {DATA_WIDTH{1'b0}});
    assign w_step = en_i && (r_count == div_i);
    // A seed write overrides the step and the pop that would share its edge.
    assign w_push = w_step && !seed_wr_i;
    assign w_pop  = ready_i && !seed_wr_i;

`ifdef RNG_WHITEN_EN
    assign w_sample = w_next ^ {w_next[DATA_WIDTH/2-1:0], w_next[DATA_WIDTH-1:DATA_WIDTH/2]};
`else
    assign w_sample = w_next;
`endif

    // Prescaler; a count left above a freshly lowered div_i wraps without stepping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= {DIV_WIDTH{1'b0}};
        end else if (seed_wr_i) begin
            r_count <= {DIV_WIDTH{1'b0}};
        end else if (en_i) begin
            if (r_count >= div_i) r_count <= {DIV_WIDTH{1'b0}};
            else                  r_count <= r_count + DIV_WIDTH'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

    // LFSR state; a zero seed would lock up, so it is replaced by the default.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lfsr <= DEFAULT_SEED;
        end else if (seed_wr_i) begin
            r_lfsr <= (seed_i == {DATA_WIDTH{1'b0}}) ? DEFAULT_SEED : seed_i;
        end else if (w_step) begin
            r_lfsr <= w_next;
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    rng_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (seed_wr_i),
        .push_i  (w_push),
        .din_i   (w_sample),
        .pop_i   (w_pop),
        .dout_o  (data_o),
        .valid_o (valid_o),
        .level_o (level_o),
        .full_o  (full_o)
    );

endmodule
